axil_master: RTL and testbench
==============================

AXIL_MASTER -- requirements
Module: axil_master

Interface
REQ-001 Parameter P_ADDR_WIDTH, default 8, AXI4-Lite address width in bits.
REQ-002 Parameter P_DATA_WIDTH, default 32, AXI4-Lite data width in bits (32 or 64).
REQ-003 ACLK  in  1  single clock; all logic SHALL be clocked on its rising edge.
REQ-004 ARESET  in  1  reset, synchronous, active-high.
REQ-005 cmd_valid  in  1  command request.
REQ-006 cmd_ready  out  1  command accepted on cmd_valid&cmd_ready.
REQ-007 cmd_write  in  1  1 = write, 0 = read.
REQ-008 cmd_addr  in  P_ADDR_WIDTH  target byte address.
REQ-009 cmd_wdata  in  P_DATA_WIDTH  write data; ignored on reads.
REQ-010 cmd_wstrb  in  P_DATA_WIDTH/8  write byte strobes; ignored on reads.
REQ-011 cmd_prot  in  3  protection type driven on AWPROT/ARPROT.
REQ-012 rsp_valid  out  1  transaction complete; response fields valid.
REQ-013 rsp_ready  in  1  response consumed on rsp_valid&rsp_ready.
REQ-014 rsp_rdata  out  P_DATA_WIDTH  read data; 0 for writes.
REQ-015 rsp_resp  out  2  captured BRESP or RRESP.
REQ-016 busy  out  1  high whenever state is not IDLE.
REQ-017 m_awvalid/m_awready/m_awaddr/m_awprot, m_wvalid/m_wready/m_wdata/m_wstrb, m_bvalid/m_bready/m_bresp, m_arvalid/m_arready/m_araddr/m_arprot, m_rvalid/m_rready/m_rdata/m_rresp: AXI4-Lite manager ports, standard directions and widths per P_ADDR_WIDTH/P_DATA_WIDTH.

Function
REQ-018 The block SHALL issue exactly one AXI4-Lite transaction per accepted command; no outstanding-transaction overlap.
REQ-019 States SHALL be IDLE, WADDR (AW and/or W pending), WRESP, RADDR, RDATA, RESP.
REQ-020 cmd_ready SHALL be a registered output, 1 only in IDLE.
REQ-021 Command accepted at edge N: address, data, strobes, prot SHALL be latched; write -> WADDR, read -> RADDR; m_awvalid and m_wvalid (or m_arvalid) SHALL be 1 from cycle N+1.
REQ-022 In WADDR, m_awvalid and m_wvalid SHALL each deassert the cycle after its own handshake, independently; either order or same-cycle handshake SHALL be supported.
REQ-023 WADDR -> WRESP after both AW and W handshakes complete; m_bready SHALL be 1 only in WRESP.
REQ-024 RADDR -> RDATA the cycle after the AR handshake; m_rready SHALL be 1 only in RDATA.
REQ-025 On B (or R) handshake, bresp (or rdata, rresp) SHALL be captured; state -> RESP; rsp_valid SHALL be 1 the following cycle.
REQ-026 rsp_valid and response fields SHALL hold stable until rsp_ready; on handshake -> IDLE, cmd_ready 1 the next cycle.
REQ-027 Valid signals SHALL never depend combinationally on ready inputs; once asserted, a valid and its payload SHALL stay stable until handshake.
REQ-028 Minimum latency with ready always high: cmd accept N, AW/W handshake N+1, B handshake N+2, rsp_valid N+3; same for reads.
REQ-029 SLVERR/DECERR responses SHALL be passed through unchanged on rsp_resp; no retry.
REQ-030 cmd_valid while not IDLE SHALL be ignored (cmd_ready 0).

Reset
REQ-031 While ARESET is high at an edge: state IDLE; all m_*valid, m_bready, m_rready, rsp_valid, cmd_ready, busy 0; rsp_rdata, rsp_resp 0; cmd_ready 1 the first cycle after ARESET deasserts.
REQ-032 ARESET mid-transaction SHALL abandon the transaction with no rsp_valid; the AXI subordinate SHALL share the same reset.

Verification
REQ-033 Write 0x10 <- 0xDEADBEEF, wstrb 0xF, all readies high -> AW/W at N+1, bready at N+2, rsp_valid N+3, rsp_resp 00, rsp_rdata 0.
REQ-034 Read 0x04, subordinate returns 0x12345678 after 3-cycle rvalid delay -> rsp_rdata 0x12345678, rsp_resp 00, m_araddr 0x04 stable until arready.
REQ-035 Write with awready 5 cycles after wready -> wvalid drops after W handshake, awvalid held to its handshake, single B accepted.
REQ-036 bresp 2'b10 with rsp_ready low 4 cycles -> rsp_valid, rsp_resp 10 held 4 cycles; cmd_valid ignored meanwhile.
REQ-037 ARESET asserted while in RDATA -> next cycle all valids/readies 0, busy 0, no rsp_valid; following read completes normally.

Source files
------------

// File: rtl/axil_master_if.sv
// AXI4-Lite manager/subordinate signal bundle.
// Latency: none (wires only).
// Backpressure: standard AXI4-Lite valid/ready per channel.
// Ports: AW, W, B, AR, R channels; modport master drives valids/payloads and
// B/R readies, modport slave drives the opposite side.
interface axil_master_if #(
    parameter int P_ADDR_WIDTH = 8,
    parameter int P_DATA_WIDTH = 32
);
    logic                        awvalid;
    logic                        awready;
    logic [P_ADDR_WIDTH-1:0]     awaddr;
    logic [2:0]                  awprot;
    logic                        wvalid;
    logic                        wready;
    logic [P_DATA_WIDTH-1:0]     wdata;
    logic [P_DATA_WIDTH/8-1:0]   wstrb;
    logic                        bvalid;
    logic                        bready;
    logic [1:0]                  bresp;
    logic                        arvalid;
    logic                        arready;
    logic [P_ADDR_WIDTH-1:0]     araddr;
    logic [2:0]                  arprot;
    logic                        rvalid;
    logic                        rready;
    logic [P_DATA_WIDTH-1:0]     rdata;
    logic [1:0]                  rresp;

    modport master (
        output awvalid, awaddr, awprot, wvalid, wdata, wstrb, bready,
               arvalid, araddr, arprot, rready,
        input  awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
    );

    modport slave (
        input  awvalid, awaddr, awprot, wvalid, wdata, wstrb, bready,
               arvalid, araddr, arprot, rready,
        output awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
    );
endinterface

// File: rtl/axil_master.sv
// Converts single cmd/rsp requests into one AXI4-Lite read or write at a time.
// Latency: cmd accept N, AW/W (or AR) handshake N+1, B (or R) N+2, rsp_valid N+3.
// Backpressure: cmd_ready only in IDLE; rsp held until rsp_ready; AXI readies stall per channel.
// Ports: ACLK/ARESET (sync, active-high); cmd_* request in; rsp_* response out;
// busy = not IDLE; m = AXI4-Lite manager side (axil_master_if.master).
module axil_master #(
    parameter int P_ADDR_WIDTH = 8,
    parameter int P_DATA_WIDTH = 32
) (
    input  logic                      ACLK,
    input  logic                      ARESET,
    input  logic                      cmd_valid,
    output logic                      cmd_ready,
    input  logic                      cmd_write,
    input  logic [P_ADDR_WIDTH-1:0]   cmd_addr,
    input  logic [P_DATA_WIDTH-1:0]   cmd_wdata,
    input  logic [P_DATA_WIDTH/8-1:0] cmd_wstrb,
    input  logic [2:0]                cmd_prot,
    output logic                      rsp_valid,
    input  logic                      rsp_ready,
    output logic [P_DATA_WIDTH-1:0]   rsp_rdata,
    output logic [1:0]                rsp_resp,
    output logic                      busy,
    axil_master_if.master             m
);
    typedef enum logic [2:0] {
        S_IDLE, S_WADDR, S_WRESP, S_RADDR, S_RDATA, S_RESP
    } state_t;

    state_t                      state_q;
    logic                        cmd_ready_q;
    logic                        awvalid_q;
    logic                        wvalid_q;
    logic                        arvalid_q;
    logic                        bready_q;
    logic                        rready_q;
    logic                        rsp_valid_q;
    logic [P_ADDR_WIDTH-1:0]     addr_q;
    logic [P_DATA_WIDTH-1:0]     wdata_q;
    logic [P_DATA_WIDTH/8-1:0]   wstrb_q;
    logic [2:0]                  prot_q;
    logic [P_DATA_WIDTH-1:0]     rsp_rdata_q;
    logic [1:0]                  rsp_resp_q;

    // AW and W retire independently: each valid stays up only while its own
    // handshake has not yet happened.
    logic aw_pend_d;
    logic w_pend_d;
    assign aw_pend_d = awvalid_q & ~m.awready;
    assign w_pend_d  = wvalid_q  & ~m.wready;

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            state_q     <= S_IDLE;
            cmd_ready_q <= 1'b0;
            awvalid_q   <= 1'b0;
            wvalid_q    <= 1'b0;
            arvalid_q   <= 1'b0;
            bready_q    <= 1'b0;
            rready_q    <= 1'b0;
            rsp_valid_q <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            wstrb_q     <= '0;
            prot_q      <= '0;
            rsp_rdata_q <= '0;
            rsp_resp_q  <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    cmd_ready_q <= 1'b1;
                    if (cmd_valid && cmd_ready_q) begin
                        cmd_ready_q <= 1'b0;
                        addr_q      <= cmd_addr;
                        wdata_q     <= cmd_wdata;
                        wstrb_q     <= cmd_wstrb;
                        prot_q      <= cmd_prot;
                        if (cmd_write) begin
                            awvalid_q <= 1'b1;
                            wvalid_q  <= 1'b1;
                            state_q   <= S_WADDR;
                        end else begin
                            arvalid_q <= 1'b1;
                            state_q   <= S_RADDR;
                        end
                    end
                end
                S_WADDR: begin
                    awvalid_q <= aw_pend_d;
                    wvalid_q  <= w_pend_d;
                    if (!aw_pend_d && !w_pend_d) begin
                        bready_q <= 1'b1;
                        state_q  <= S_WRESP;
                    end
                end
                S_WRESP: begin
                    if (m.bvalid) begin
                        bready_q    <= 1'b0;
                        rsp_resp_q  <= m.bresp;
                        rsp_rdata_q <= '0;
                        rsp_valid_q <= 1'b1;
                        state_q     <= S_RESP;
                    end
                end
                S_RADDR: begin
                    if (m.arready) begin
                        arvalid_q <= 1'b0;
                        rready_q  <= 1'b1;
                        state_q   <= S_RDATA;
                    end
                end
                S_RDATA: begin
                    if (m.rvalid) begin
                        rready_q    <= 1'b0;
                        rsp_resp_q  <= m.rresp;
                        rsp_rdata_q <= m.rdata;
                        rsp_valid_q <= 1'b1;
                        state_q     <= S_RESP;
                    end
                end
                S_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        cmd_ready_q <= 1'b1;
                        state_q     <= S_IDLE;
                    end
                end
                default: begin
                    cmd_ready_q <= 1'b0;
                    state_q     <= S_IDLE;
                end
            endcase
        end
    end

    assign cmd_ready = cmd_ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_resp  = rsp_resp_q;
    assign busy      = (state_q != S_IDLE);

    // One shared address/prot register serves both AW and AR; only the
    // channel matching the command direction is ever validated.
    assign m.awvalid = awvalid_q;
    assign m.awaddr  = addr_q;
    assign m.awprot  = prot_q;
    assign m.wvalid  = wvalid_q;
    assign m.wdata   = wdata_q;
    assign m.wstrb   = wstrb_q;
    assign m.bready  = bready_q;
    assign m.arvalid = arvalid_q;
    assign m.araddr  = addr_q;
    assign m.arprot  = prot_q;
    assign m.rready  = rready_q;
endmodule

// File: tb/tb_axil_master.sv
// Directed bench for axil_master: table of transactions against a
// delay-configurable subordinate, plus reset sequences.
// Interval k below means the clock period just after edge N+k (N = accept edge).
module tb_axil_master;
    localparam int AW = 8;
    localparam int DW = 32;

    logic            clk = 1'b0;
    logic            ARESET;
    logic            cmd_valid;
    logic            cmd_ready;
    logic            cmd_write;
    logic [AW-1:0]   cmd_addr;
    logic [DW-1:0]   cmd_wdata;
    logic [DW/8-1:0] cmd_wstrb;
    logic [2:0]      cmd_prot;
    logic            rsp_valid;
    logic            rsp_ready;
    logic [DW-1:0]   rsp_rdata;
    logic [1:0]      rsp_resp;
    logic            busy;

    always #5 clk = ~clk;

    axil_master_if #(.P_ADDR_WIDTH(AW), .P_DATA_WIDTH(DW)) bus ();

    axil_master #(.P_ADDR_WIDTH(AW), .P_DATA_WIDTH(DW)) dut (
        .ACLK(clk), .ARESET(ARESET),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
        .cmd_prot(cmd_prot), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp), .busy(busy), .m(bus)
    );

    typedef struct {
        string           name;
        bit              wr;
        logic [AW-1:0]   addr;
        logic [DW-1:0]   wdata;
        logic [DW/8-1:0] wstrb;
        logic [2:0]      prot;
        int              aw_dly, w_dly, ar_dly, b_dly, r_dly;
        logic [1:0]      resp;
        logic [DW-1:0]   rdata;
        int              hold;
        int              exp_lat;   // interval in which rsp_valid first appears
        logic [DW-1:0]   exp_rdata;
        logic [1:0]      exp_resp;
    } vec_t;

    vec_t vecs[7];
    int   n_chk = 0;
    int   n_pass = 0;

    function automatic void chk(string nm, logic [31:0] got, logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", nm, got, exp);
    endfunction

    task automatic slave_idle();
        bus.awready = 1'b0; bus.wready = 1'b0; bus.arready = 1'b0;
        bus.bvalid = 1'b0; bus.bresp = 2'b00;
        bus.rvalid = 1'b0; bus.rdata = '0; bus.rresp = 2'b00;
    endtask

    task automatic run_txn(input vec_t v);
        int k, aw_e, w_e, ar_e, b_cnt, r_cnt, rsp_first, rsp_cnt, viol, mx;
        bit done, p_aw, p_w, p_ar, p_rsp;
        logic [AW-1:0]   got_addr, p_awaddr, p_araddr;
        logic [DW-1:0]   got_wdata, got_rdata, p_wdata, p_rdata;
        logic [DW/8-1:0] got_wstrb;
        logic [2:0]      got_prot;
        logic [1:0]      got_resp, p_rresp;
        k = 0; aw_e = 0; w_e = 0; ar_e = 0; b_cnt = 0; r_cnt = 0;
        rsp_first = -1; rsp_cnt = 0; viol = 0; done = 1'b0;
        p_aw = 1'b0; p_w = 1'b0; p_ar = 1'b0; p_rsp = 1'b0;
        got_addr = '0; got_wdata = '0; got_wstrb = '0; got_prot = '0;
        got_rdata = 'x; got_resp = 'x;
        p_awaddr = '0; p_araddr = '0; p_wdata = '0; p_rdata = '0; p_rresp = '0;

        chk({v.name, " cmd_ready_idle"}, 32'(cmd_ready), 32'd1);
        cmd_valid = 1'b1; cmd_write = v.wr; cmd_addr = v.addr;
        cmd_wdata = v.wdata; cmd_wstrb = v.wstrb; cmd_prot = v.prot;
        rsp_ready = 1'b0;
        @(posedge clk);                         // accept edge N
        while (!done && k < 60) begin
            @(negedge clk);
            // keep requesting with different fields: must be ignored while busy
            cmd_write = ~v.wr; cmd_addr = ~v.addr; cmd_wdata = ~v.wdata;
            if (cmd_ready || !busy) viol++;
            if (p_aw && (!bus.awvalid || bus.awaddr !== p_awaddr)) viol++;
            if (p_w && (!bus.wvalid || bus.wdata !== p_wdata)) viol++;
            if (p_ar && (!bus.arvalid || bus.araddr !== p_araddr)) viol++;
            if (p_rsp && (!rsp_valid || rsp_rdata !== p_rdata || rsp_resp !== p_rresp)) viol++;
            if (v.wr && (bus.arvalid || bus.rready)) viol++;
            if (!v.wr && (bus.awvalid || bus.wvalid || bus.bready)) viol++;
            if (bus.awvalid && aw_e != 0) viol++;
            if (bus.wvalid && w_e != 0) viol++;
            if (bus.arvalid && ar_e != 0) viol++;
            if (bus.bready && (aw_e == 0 || w_e == 0 || b_cnt != 0)) viol++;
            if (bus.rready && (ar_e == 0 || r_cnt != 0)) viol++;

            mx = (aw_e > w_e) ? aw_e : w_e;
            bus.awready = (k >= v.aw_dly);
            bus.wready  = (k >= v.w_dly);
            bus.arready = (k >= v.ar_dly);
            bus.bvalid  = (aw_e != 0 && w_e != 0 && b_cnt == 0 && k >= mx + v.b_dly);
            bus.bresp   = bus.bvalid ? v.resp : 2'b00;
            bus.rvalid  = (ar_e != 0 && r_cnt == 0 && k >= ar_e + v.r_dly);
            bus.rdata   = bus.rvalid ? v.rdata : '0;
            bus.rresp   = bus.rvalid ? v.resp : 2'b00;
            if (rsp_valid) begin
                if (rsp_first < 0) rsp_first = k;
                rsp_cnt++;
            end
            rsp_ready = (rsp_first >= 0 && k >= rsp_first + v.hold);

            // handshakes below complete at edge N+k+1
            p_aw = bus.awvalid && !bus.awready; p_awaddr = bus.awaddr;
            p_w  = bus.wvalid && !bus.wready;   p_wdata  = bus.wdata;
            p_ar = bus.arvalid && !bus.arready; p_araddr = bus.araddr;
            p_rsp = rsp_valid && !rsp_ready;    p_rdata = rsp_rdata; p_rresp = rsp_resp;
            if (bus.awvalid && bus.awready) begin
                aw_e = k + 1; got_addr = bus.awaddr; got_prot = bus.awprot;
            end
            if (bus.wvalid && bus.wready) begin
                w_e = k + 1; got_wdata = bus.wdata; got_wstrb = bus.wstrb;
            end
            if (bus.arvalid && bus.arready) begin
                ar_e = k + 1; got_addr = bus.araddr; got_prot = bus.arprot;
            end
            if (bus.bvalid && bus.bready) b_cnt++;
            if (bus.rvalid && bus.rready) r_cnt++;
            if (rsp_valid && rsp_ready) begin
                done = 1'b1; got_rdata = rsp_rdata; got_resp = rsp_resp;
            end
            k++;
            @(posedge clk);
        end
        @(negedge clk);
        cmd_valid = 1'b0; rsp_ready = 1'b0;
        slave_idle();
        chk({v.name, " completed"}, 32'(done), 32'd1);
        chk({v.name, " rsp_latency"}, 32'(rsp_first), 32'(v.exp_lat));
        chk({v.name, " rsp_hold_cycles"}, 32'(rsp_cnt), 32'(v.hold + 1));
        chk({v.name, " rsp_rdata"}, got_rdata, v.exp_rdata);
        chk({v.name, " rsp_resp"}, 32'(got_resp), 32'(v.exp_resp));
        chk({v.name, " addr"}, 32'(got_addr), 32'(v.addr));
        chk({v.name, " prot"}, 32'(got_prot), 32'(v.prot));
        if (v.wr) begin
            chk({v.name, " wdata"}, got_wdata, v.wdata);
            chk({v.name, " wstrb"}, 32'(got_wstrb), 32'(v.wstrb));
            chk({v.name, " b_handshakes"}, 32'(b_cnt), 32'd1);
        end else begin
            chk({v.name, " r_handshakes"}, 32'(r_cnt), 32'd1);
        end
        chk({v.name, " protocol_violations"}, 32'(viol), 32'd0);
        chk({v.name, " post cmd_ready"}, 32'(cmd_ready), 32'd1);
        chk({v.name, " post busy"}, 32'(busy), 32'd0);
        chk({v.name, " post rsp_valid"}, 32'(rsp_valid), 32'd0);
    endtask

    function automatic logic [7:0] ctl_bits();
        return {cmd_ready, rsp_valid, busy, bus.awvalid, bus.wvalid,
                bus.arvalid, bus.bready, bus.rready};
    endfunction

    initial begin
        //          name              wr addr   wdata         wstrb prot    awd wd ard bd rd resp   rdata         hold lat exp_rdata     exp_resp
        vecs[0] = '{"wr_min",         1, 8'h10, 32'hDEADBEEF, 4'hF, 3'b000, 0, 0, 0, 0, 0, 2'b00, 32'h0,        0,   2,  32'h0,        2'b00};
        vecs[1] = '{"rd_rvalid_dly3", 0, 8'h04, 32'h0,        4'h0, 3'b010, 0, 0, 0, 0, 3, 2'b00, 32'h12345678, 0,   5,  32'h12345678, 2'b00};
        vecs[2] = '{"wr_aw_late5",    1, 8'h20, 32'h0BADF00D, 4'hF, 3'b000, 5, 0, 0, 0, 0, 2'b00, 32'h0,        0,   7,  32'h0,        2'b00};
        vecs[3] = '{"wr_slverr_hold", 1, 8'h30, 32'h11223344, 4'h5, 3'b001, 0, 0, 0, 0, 0, 2'b10, 32'h0,        4,   2,  32'h0,        2'b10};
        vecs[4] = '{"rd_decerr",      0, 8'hFC, 32'h0,        4'h0, 3'b111, 0, 0, 2, 0, 0, 2'b11, 32'hCAFEF00D, 0,   4,  32'hCAFEF00D, 2'b11};
        vecs[5] = '{"wr_w_late3",     1, 8'h44, 32'h55AA55AA, 4'h3, 3'b100, 0, 3, 0, 2, 0, 2'b11, 32'hFFFFFFFF, 0,   7,  32'h0,        2'b11};
        vecs[6] = '{"rd_min",         0, 8'h08, 32'h0,        4'h0, 3'b101, 0, 0, 0, 0, 0, 2'b00, 32'hA5A50F0F, 0,   2,  32'hA5A50F0F, 2'b00};

        ARESET = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0;
        cmd_wdata = '0; cmd_wstrb = '0; cmd_prot = '0; rsp_ready = 1'b0;
        slave_idle();
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset ctl outputs", 32'(ctl_bits()), 32'd0);
        chk("reset rsp_rdata", rsp_rdata, 32'd0);
        chk("reset rsp_resp", 32'(rsp_resp), 32'd0);
        ARESET = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("post-reset cmd_ready", 32'(cmd_ready), 32'd1);

        for (int i = 0; i < 7; i++) run_txn(vecs[i]);

        // reset while waiting in RDATA: transaction abandoned silently
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 8'h20; cmd_prot = 3'b000;
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
        chk("midrst arvalid", 32'(bus.arvalid), 32'd1);
        bus.arready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.arready = 1'b0;
        chk("midrst in RDATA rready", 32'(bus.rready), 32'd1);
        ARESET = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("midrst ctl outputs", 32'(ctl_bits()), 32'd0);
        chk("midrst rsp_rdata", rsp_rdata, 32'd0);
        chk("midrst rsp_resp", 32'(rsp_resp), 32'd0);
        ARESET = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("midrst release cmd_ready", 32'(cmd_ready), 32'd1);
        chk("midrst release rsp_valid", 32'(rsp_valid), 32'd0);
        run_txn(vecs[6]);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
